// File: rtl/regfile_wb_queue_pkg.sv
// Shared widths and types for the register-file write-back queue.
// Regfiles and the queue agree on these sizes.
package regfile_wb_queue_pkg;

    localparam int WBQ_DATA_W = 32;
    localparam int WBQ_ADDR_W = 5;
    localparam int WBQ_PTR_W  = 2;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wbq_fifo.sv
// Write-back FIFO: entry storage, pointers, occupancy count.
// Exposes every entry so the top can do the pending-write lookup.
module wbq_fifo
    import regfile_wb_queue_pkg::*;
#(
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W,
    parameter int PTR_W  = WBQ_PTR_W,
    localparam int DEPTH = 2 ** PTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DEPTH-1:0]  ent_valid,
    output logic [ADDR_W-1:0] ent_addr [DEPTH],
    output logic [DATA_W-1:0] ent_data [DEPTH],
    output logic [PTR_W-1:0]  rd_ptr,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);

    logic [PTR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (push_ok) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: the valid bits and count gate every use.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = addr_q[i];
            ent_data[i] = data_q[i];
        end
    end

    assign head_addr = empty ? '0 : addr_q[rd_ptr];
    assign head_data = empty ? '0 : data_q[rd_ptr];

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the Regfiles write port.
// Arbitrates two producers, drains one write per cycle, offers bypass lookup.
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W,
    parameter int PTR_W  = WBQ_PTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              hold,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              pend_hit,
    output logic [DATA_W-1:0] pend_data,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full
);

    localparam int DEPTH = 2 ** PTR_W;

    wb_src_e           src;
    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic [DEPTH-1:0]  ent_valid;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;

    // Ready never looks at a same-cycle pop, so a full queue stalls both.
    assign a_ready = !rst && !full;
    assign b_ready = !rst && !full && !a_valid;

    always_comb begin
        src = SRC_NONE;
        unique case (1'b1)
            (a_valid && a_ready): src = SRC_A;
            (b_valid && b_ready): src = SRC_B;
            default:              src = SRC_NONE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_addr = '0;
        push_data = '0;
        unique case (src)
            SRC_A: begin
                push      = 1'b1;
                push_addr = a_addr;
                push_data = a_data;
            end
            SRC_B: begin
                push      = 1'b1;
                push_addr = b_addr;
                push_data = b_data;
            end
            default: begin
                push      = 1'b0;
                push_addr = '0;
                push_data = '0;
            end
        endcase
    end

    assign rf_we = !empty && !hold && !rst;

    wbq_fifo #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_addr(push_addr),
        .push_data(push_data),
        .pop      (rf_we),
        .ent_valid(ent_valid),
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .rd_ptr   (rd_ptr),
        .head_addr(rf_waddr),
        .head_data(rf_wdata),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Walk oldest to youngest from the head; the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        pend_hit  = 1'b0;
        pend_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (ent_valid[idx] && (ent_addr[idx] == lk_addr)) begin
                pend_hit  = 1'b1;
                pend_data = ent_data[idx];
            end
        end
    end

endmodule
